wb_slave_port_arbiter: RTL

- Per-slave-port arbiter for the Wishbone N-master interconnect. Shares one slave port between N_MASTERS requesters using round-robin, CYC-locked ownership.
- Adds a bus watchdog: a hung slave is converted into a one-cycle ERR to the owning master.
- One instance per slave port. The interconnect muxes ADR/DAT/SEL/WE/STB/CTI/BTE using gnt_id, and ORs to_err into the owner's ERR.

---
 rtl/wb_ic_pkg.sv | 17 +
 rtl/wb_slave_port_arbiter_if.sv | 29 ++
 rtl/wb_rr_pick.sv | 37 +++
 rtl/wb_slave_port_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wb_ic_pkg.sv
// Shared types and helpers for the Wishbone N-master interconnect.
// Imported by the slave-port arbiter, its interface and the rotating picker.
package wb_ic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Sentinel index meaning "no master selected" in decode/arbitration paths.
    localparam int NO_MASTER = -1;

    function automatic int masterid_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_slave_port_arbiter_if.sv
// Per-slave-port arbitration bundle: decoded master requests, slave response, grant outputs.
// Handshake: a master owns the port from the edge gnt_valid rises until the edge after its cyc falls; to_err is a one-cycle pulse.
interface wb_slave_port_arbiter_if
    import wb_ic_pkg::*;
#(
    parameter int N_MASTERS       = 3,
    parameter int N_MASTERID_BITS = masterid_bits(N_MASTERS)
);
    logic [N_MASTERS-1:0]       cyc;
    logic [N_MASTERS-1:0]       stb;
    logic                       sack;
    logic                       serr;
    logic [N_MASTERS-1:0]       gnt;
    logic [N_MASTERID_BITS-1:0] gnt_id;
    logic                       gnt_valid;
    logic                       to_err;

    // Arbiter side.
    modport slave (
        input  cyc, stb, sack, serr,
        output gnt, gnt_id, gnt_valid, to_err
    );

    // Interconnect side: drives requests and the slave response, observes the grant.
    modport master (
        output cyc, stb, sack, serr,
        input  gnt, gnt_id, gnt_valid, to_err
    );
endinterface

// File: rtl/wb_rr_pick.sv
// Combinational rotating-priority picker: first eligible request scanning upward from last_id+1.
// Also used by the address-decode error path of the interconnect.
module wb_rr_pick
    import wb_ic_pkg::*;
#(
    parameter int N   = 3,
    parameter int IDW = masterid_bits(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    input  logic [N-1:0]   exclude,
    output logic           found,
    output logic [IDW-1:0] idx
);
    logic [N-1:0] elig;

    assign elig = req & ~exclude;

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        // last_id itself is visited last, so a re-requesting owner has lowest priority.
        for (int i = 1; i <= N; i++) begin
            cand = int'(last_id) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && elig[IDW'(cand)]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_slave_port_arbiter.sv
// Round-robin, CYC-locked owner selection for one Wishbone slave port,
// with a watchdog that turns a hung slave into a one-cycle error for the owner.
module wb_slave_port_arbiter
    import wb_ic_pkg::*;
#(
    parameter int N_MASTERS       = 3,
    parameter int TIMEOUT         = 256,
    parameter int N_MASTERID_BITS = masterid_bits(N_MASTERS)
) (
    input  logic                         clk,
    input  logic                         rst,
    wb_slave_port_arbiter_if.slave       bus,
    output arb_state_e                   state_dbg
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [N_MASTERID_BITS-1:0] RESET_LAST = N_MASTERID_BITS'(N_MASTERS - 1);

    arb_state_e                 state_q, state_d;
    logic [N_MASTERS-1:0]       gnt_q, gnt_d;
    logic [N_MASTERID_BITS-1:0] gnt_id_q, gnt_id_d;
    logic                       gnt_valid_q, gnt_valid_d;
    logic                       to_err_q, to_err_d;
    logic [N_MASTERID_BITS-1:0] last_id_q, last_id_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic                       pick_found;
    logic [N_MASTERID_BITS-1:0] pick_idx;
    logic [N_MASTERS-1:0]       pick_excl;
    logic                       owner_cyc;
    logic                       owner_stb;
    logic                       waiting;

    assign owner_cyc = bus.cyc[gnt_id_q];
    assign owner_stb = bus.stb[gnt_id_q];
    assign waiting   = owner_stb && !bus.sack && !bus.serr;
    // The outgoing owner is excluded so a hand-off always moves to someone else.
    assign pick_excl = (state_q == OWNED) ? gnt_q : '0;

    wb_rr_pick #(
        .N   (N_MASTERS),
        .IDW (N_MASTERID_BITS)
    ) u_pick (
        .req     (bus.cyc),
        .last_id (last_id_q),
        .exclude (pick_excl),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        last_id_d   = last_id_q;
        to_err_d    = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    state_d     = OWNED;
                    gnt_d       = N_MASTERS'(1) << pick_idx;
                    gnt_id_d    = pick_idx;
                    gnt_valid_d = 1'b1;
                    last_id_d   = pick_idx;
                end
            end
            OWNED: begin
                if (!owner_cyc) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        gnt_d     = N_MASTERS'(1) << pick_idx;
                        gnt_id_d  = pick_idx;
                        last_id_d = pick_idx;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_id_d    = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (TIMEOUT > 0 && waiting) begin
                    // Ownership is kept after a timeout; the master must drop CYC itself.
                    if (cnt_q == CNT_LAST) begin
                        to_err_d = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            to_err_q    <= 1'b0;
            last_id_q   <= RESET_LAST;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            to_err_q    <= to_err_d;
            last_id_q   <= last_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.to_err    = to_err_q;
    assign state_dbg     = state_q;

endmodule
